matrix_display_reader: RTL and testbench

MATRIX_DISPLAY_READER -- requirements
Module: matrix_display_reader

---
 rtl/matrix_display_reader.sv | 185 ++++++++++++++++++
 tb/tb_matrix_display_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_display_reader.sv
// Fetches a stored matrix (dims + signed 8-bit elements) and prints it as an
// ASCII stream: "MxN\r\n" header, then rows of decimal values.
module matrix_display_reader #(
  parameter int META_TIMEOUT = 8,
  parameter int DATA_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] matrix_id,
  output logic       start_disp,
  output logic [3:0] disp_id,
  input  logic       meta_info_valid,
  input  logic [2:0] meta_m,
  input  logic [2:0] meta_n,
  output logic       read_en,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  input  logic       store_error,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE, REQ, WAIT_META, HDR, FETCH, WAIT_DATA, EMIT, SEP, FIN, FAIL
  } state_t;

  state_t state, state_nx;

  logic [2:0] m_r, n_r, row, col, idx;
  logic [7:0] data_r;
  logic [7:0] cnt;

  // element -> decimal digits; magnitude needs 9 bits so -128 maps to 128
  logic       neg, hund;
  logic [8:0] mag, rem;
  logic [3:0] tens, ones;

  assign neg  = data_r[7];
  assign mag  = neg ? (9'd256 - {1'b0, data_r}) : {1'b0, data_r};
  assign hund = (mag >= 9'd100);
  assign rem  = hund ? (mag - 9'd100) : mag;
  assign tens = 4'(rem / 9'd10);
  assign ones = 4'(rem % 9'd10);

  logic is_last_col, is_last_elem, bad_dims;

  assign is_last_col  = (col == n_r - 3'd1);
  assign is_last_elem = is_last_col && (row == m_r - 3'd1);
  assign bad_dims     = (meta_m == 3'd0) || (meta_m > 3'd5) ||
                        (meta_n == 3'd0) || (meta_n > 3'd5);

  // byte list for the current emitting state, indexed by idx
  logic [4:0][7:0] bytes;
  logic [2:0]      len, p;

  always_comb begin
    bytes = '0;
    len   = 3'd1;
    p     = 3'd0;
    case (state)
      HDR: begin
        bytes[0] = 8'h30 + {5'd0, m_r};
        bytes[1] = 8'h78;
        bytes[2] = 8'h30 + {5'd0, n_r};
        bytes[3] = 8'h0D;
        bytes[4] = 8'h0A;
        len      = 3'd5;
      end
      EMIT: begin
        if (neg) begin
          bytes[p] = 8'h2D;
          p        = p + 3'd1;
        end
        if (hund) begin
          bytes[p] = 8'h31;
          p        = p + 3'd1;
        end
        if (hund || tens != 4'd0) begin
          bytes[p] = 8'h30 + {4'd0, tens};
          p        = p + 3'd1;
        end
        bytes[p] = 8'h30 + {4'd0, ones};
        len      = p + 3'd1;
      end
      SEP: begin
        if (is_last_col) begin
          bytes[0] = 8'h0D;
          bytes[1] = 8'h0A;
          len      = 3'd2;
        end else begin
          bytes[0] = 8'h20;
        end
      end
      default: ;
    endcase
  end

  logic fire, last_byte;

  assign tx_valid   = (state == HDR) || (state == EMIT) || (state == SEP);
  assign tx_data    = tx_valid ? bytes[idx] : 8'h00;
  assign fire       = tx_valid && tx_ready;
  assign last_byte  = (idx == len - 3'd1);
  assign start_disp = (state == REQ);
  assign read_en    = (state == FETCH);
  assign done       = (state == FIN);
  assign err        = (state == FAIL);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = REQ;
      REQ:       state_nx = WAIT_META;
      WAIT_META: begin
        if (store_error)                         state_nx = FAIL;
        else if (meta_info_valid)                state_nx = bad_dims ? FAIL : HDR;
        else if (cnt == 8'(META_TIMEOUT - 1))    state_nx = FAIL;
      end
      HDR:       if (fire && last_byte) state_nx = FETCH;
      FETCH:     state_nx = WAIT_DATA;
      WAIT_DATA: begin
        if (data_valid)                          state_nx = EMIT;
        else if (cnt == 8'(DATA_TIMEOUT - 1))    state_nx = FAIL;
      end
      EMIT:      if (fire && last_byte) state_nx = SEP;
      SEP:       if (fire && last_byte) state_nx = is_last_elem ? FIN : FETCH;
      FIN:       state_nx = IDLE;
      FAIL:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      disp_id <= '0;
      m_r     <= '0;
      n_r     <= '0;
      row     <= '0;
      col     <= '0;
      data_r  <= '0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          disp_id <= matrix_id;
          row     <= '0;
          col     <= '0;
        end
        REQ, FETCH: cnt <= '0;
        WAIT_META: begin
          cnt <= cnt + 8'd1;
          if (meta_info_valid) begin
            m_r <= meta_m;
            n_r <= meta_n;
          end
        end
        WAIT_DATA: begin
          cnt <= cnt + 8'd1;
          if (data_valid) data_r <= data_in;
        end
        SEP: if (fire && last_byte) begin
          if (is_last_col) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        default: ;
      endcase
      if (!tx_valid)  idx <= '0;
      else if (fire)  idx <= last_byte ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_matrix_display_reader.sv
// Bench for matrix_display_reader: storage responder, byte monitor and a
// string-level model of the expected print stream.
module tb_matrix_display_reader;
  localparam int MT = 8;
  localparam int DT = 8;

  logic       clk, rst, start;
  logic [3:0] matrix_id, disp_id;
  logic       start_disp, meta_info_valid, read_en, data_valid, store_error;
  logic [2:0] meta_m, meta_n;
  logic [7:0] data_in, tx_data;
  logic       tx_valid, tx_ready, busy, done, err;

  matrix_display_reader #(.META_TIMEOUT(MT), .DATA_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix_id(matrix_id),
    .start_disp(start_disp), .disp_id(disp_id),
    .meta_info_valid(meta_info_valid), .meta_m(meta_m), .meta_n(meta_n),
    .read_en(read_en), .data_valid(data_valid), .data_in(data_in),
    .store_error(store_error), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scenario knobs (written only by the main process)
  int mode;   // 0 normal, 1 no meta, 2 store_error, 3 no data
  int rmode;  // 0 ready high, 1 toggle, 2 random
  int sm, sn;
  int mem[25];

  int tests = 0, fails = 0;

  // storage responder
  initial begin
    int k, rptr;
    meta_info_valid = 0; meta_m = 0; meta_n = 0;
    data_valid = 0; data_in = 0; store_error = 0; rptr = 0;
    forever begin
      @(negedge clk);
      if (start_disp && !rst) begin
        rptr = 0;
        if (mode == 2) begin
          @(posedge clk); @(posedge clk); #1 store_error = 1;
          @(posedge clk); #1 store_error = 0;
        end else if (mode != 1) begin
          k = $urandom_range(1, 3);
          repeat (k) @(posedge clk);
          #1 meta_info_valid = 1; meta_m = 3'(sm); meta_n = 3'(sn);
          @(posedge clk); #1 meta_info_valid = 0;
        end
      end else if (read_en && !rst && mode != 3) begin
        k = $urandom_range(1, 3);
        repeat (k) @(posedge clk);
        #1 data_valid = 1; data_in = 8'(mem[rptr]); rptr++;
        @(posedge clk); #1 data_valid = 0; data_in = 8'($urandom);
      end
    end
  end

  // sink ready pattern
  initial begin
    tx_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1;
      endcase
    end
  end

  // monitor: accepted bytes, pulse bookkeeping, stall stability
  byte unsigned rx[$];
  int  cyc = 0, sd_cnt = 0, done_cnt = 0, err_cnt = 0;
  int  sd_cyc = 0, rd_cyc = 0, err_cyc = 0, sd_id = 0;
  int  mon_tests = 0, mon_fails = 0;
  logic [7:0] prev_data = 0;
  bit prev_stall = 0, prev_rst = 1;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      if (start_disp) begin sd_cnt++; sd_cyc = cyc; sd_id = int'(disp_id); end
      if (read_en) rd_cyc = cyc;
      if (done) done_cnt++;
      if (err) begin err_cnt++; err_cyc = cyc; end
    end
    if (prev_stall && !prev_rst) begin
      mon_tests++;
      if (!(tx_valid && tx_data == prev_data)) begin
        mon_fails++;
        $display("FAIL stall_hold: got valid=%0b data=%02h, want valid=1 data=%02h",
                 tx_valid, tx_data, prev_data);
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_rst   = rst;
  end

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'd13)      r = {r, "\\r"};
      else if (s[i] == 8'd10) r = {r, "\\n"};
      else                    r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  task automatic chk_s(input string name, input string got, input string want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, esc(got), esc(want));
    end
  endtask

  // reference model: the text a correct print of mem as m x n produces
  function automatic string header(input int m, input int n);
    return $sformatf("%0dx%0d\r\n", m, n);
  endfunction

  function automatic string model(input int m, input int n);
    string s = header(m, n);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        s = {s, $sformatf("%0d", mem[r*n + c])};
        if (c == n - 1) s = {s, "\r\n"};
        else            s = {s, " "};
      end
    return s;
  endfunction

  function automatic string rx_str(input int base);
    string s = "";
    for (int i = base; i < rx.size(); i++) s = {s, $sformatf("%c", rx[i])};
    return s;
  endfunction

  task automatic rand_mem();
    for (int j = 0; j < 25; j++) mem[j] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, int'({start_disp, read_en, tx_valid, busy, done, err, tx_data, disp_id}), 0);
  endtask

  task automatic run(input string name, input int id, input int m, input int n,
                     input int rm, input int md, input bit extra, input bit exp_err);
    int base, sd0, d0, e0;
    bit fin;
    string want;
    mode = md; rmode = rm; sm = m; sn = n;
    base = rx.size(); sd0 = sd_cnt; d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1 start = 1; matrix_id = 4'(id);
    @(posedge clk); #1 start = 0;
    fin = 0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      @(posedge clk); #1;
      start = extra && (t == 2 || t == 9);
      matrix_id = 4'(id + 5);
      if (done_cnt != d0 || err_cnt != e0) fin = 1;
    end
    start = 0;
    chk({name, "_finished"}, int'(fin), 1);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_busy_idle"}, int'(busy), 0);
    chk({name, "_start_disp_cnt"}, sd_cnt - sd0, 1);
    chk({name, "_disp_id"}, sd_id, id);
    chk({name, "_done_cnt"}, done_cnt - d0, exp_err ? 0 : 1);
    chk({name, "_err_cnt"}, err_cnt - e0, exp_err ? 1 : 0);
    if (!exp_err)       want = model(m, n);
    else if (md == 3)   want = header(m, n);
    else                want = "";
    chk_s({name, "_stream"}, rx_str(base), want);
  endtask

  initial begin
    int base, m, n;
    bit hit;
    mode = 0; rmode = 0; sm = 1; sn = 1;
    rst = 1; start = 0; matrix_id = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset_outs");
    rst = 0;
    repeat (2) @(posedge clk);

    // 2x2 [1,-5;0,127], ready high, extra starts while busy
    mem[0] = 1; mem[1] = -5; mem[2] = 0; mem[3] = 127;
    chk_s("model_pin_2x2", model(2, 2), "2x2\r\n1 -5\r\n0 127\r\n");
    run("m2x2", 2, 2, 2, 0, 0, 1, 0);

    // 1x1 -128 with toggling ready
    mem[0] = -128;
    chk_s("model_pin_1x1", model(1, 1), "1x1\r\n-128\r\n");
    run("m1x1_neg128", 1, 1, 1, 1, 0, 0, 0);

    // digit boundaries
    mem[0] = 0; mem[1] = 100; mem[2] = -100; mem[3] = 99; mem[4] = -1; mem[5] = 10;
    run("digits_2x3", 7, 2, 3, 2, 0, 1, 0);

    // storage error, meta timeout, data timeout, bad dims
    run("store_err", 3, 2, 2, 0, 2, 0, 1);
    run("meta_to", 4, 2, 2, 0, 1, 0, 1);
    chk("meta_to_latency", err_cyc - sd_cyc, MT + 1);
    rand_mem();
    run("data_to", 5, 2, 3, 0, 3, 0, 1);
    chk("data_to_latency", err_cyc - rd_cyc, DT + 1);
    run("bad_m0", 6, 0, 3, 0, 0, 0, 1);
    run("bad_n6", 8, 2, 6, 0, 0, 0, 1);

    // randomized prints
    for (int i = 0; i < 6; i++) begin
      m = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      rand_mem();
      run($sformatf("rand%0d", i), $urandom_range(0, 15), m, n,
          $urandom_range(0, 2), 0, (m * n >= 4), 0);
    end
    mem[0] = 127; mem[1] = -128;
    run("m5x5_edges", 15, 5, 5, 2, 0, 1, 0);

    // reset mid-element in a 3x3, then a clean 3x3
    rand_mem();
    mode = 0; rmode = 2; sm = 3; sn = 3;
    base = rx.size();
    @(posedge clk); #1 start = 1; matrix_id = 4'd9;
    @(posedge clk); #1 start = 0;
    hit = 0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(posedge clk); #1;
      if (rx.size() - base >= 10 && tx_valid) hit = 1;
    end
    chk("midreset_reached", int'(hit), 1);
    rst = 1;
    @(posedge clk); #1;
    chk_reset_outs("midreset_outs");
    rst = 0;
    repeat (6) @(posedge clk);
    rand_mem();
    run("after_reset_3x3", 10, 3, 3, 2, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests + mon_tests, fails + mon_fails);
    $finish;
  end
endmodule
